mem_access_stage: RTL and testbench

- Pipeline MEM stage of the RV64 core. Sits directly downstream of the Execute stage.
- Registers Execute's ALU result, store data, rd and control bits.
- Performs loads and stores over a req/gnt/rvalid data-memory port, handling byte-lane steering and load sign/zero extension.
- Presents the write-back result, rd and reg-write to WB and to the forwarding path.
- Raises a stall while a memory transaction is outstanding.

---
 rtl/mem_access_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV64 pipeline MEM stage.
//   Registers the Execute-stage op, runs loads/stores over a req/gnt/rvalid
//   data-memory port, and presents the write-back result to WB/forwarding.
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   alu_result_i .. reg_write_i  Execute-stage op (captured when not stalled)
//   dmem_*_o / dmem_*_i      data-memory request / response handshake
//   mem_result_o, rd_o, reg_write_o  write-back value, destination, enable
//   stall_o                  freeze upstream while a transaction is pending
//   misalign_o               held op is a misaligned memory access
module mem_access_stage #(
    parameter int XLEN = 64,
    parameter int BE_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] wr_ram_data_i,
    input  logic [4:0]      rd_i,
    input  logic [2:0]      funct3_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic            reg_write_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [BE_W-1:0] dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic [XLEN-1:0] mem_result_o,
    output logic [4:0]      rd_o,
    output logic            reg_write_o,
    output logic            stall_o,
    output logic            misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] alu_result_q, alu_result_d;
    logic [XLEN-1:0] wr_ram_data_q, wr_ram_data_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic            reg_write_q, reg_write_d;

    logic            is_mem, is_store, misalign;
    logic [2:0]      off;
    logic [XLEN-1:0] shifted, load_val;

    // size code is funct3[1:0]: 0=B, 1=H, 2=W, 3=D
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr);
        case (size)
            2'd1:    return addr[0];
            2'd2:    return |addr[1:0];
            2'd3:    return |addr;
            default: return 1'b0;
        endcase
    endfunction

    assign is_mem   = mem_read_q | mem_write_q;
    assign is_store = mem_write_q;   // read+write together is treated as a store
    assign off      = alu_result_q[2:0];
    assign misalign = is_mem & is_misaligned(funct3_q[1:0], off);

    always_comb begin
        stall_o = ((state_q == REQ) && !(is_store && dmem_gnt_i)) ||
                  ((state_q == RESP) && !dmem_rvalid_i);
    end

    // Stage capture and next state. The next state is decided from the op
    // being captured, so a completing op hands over to the next one with no gap.
    always_comb begin
        alu_result_d  = alu_result_q;
        wr_ram_data_d = wr_ram_data_q;
        rd_d          = rd_q;
        funct3_d      = funct3_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        reg_write_d   = reg_write_q;
        state_d       = state_q;
        if (!stall_o) begin
            alu_result_d  = alu_result_i;
            wr_ram_data_d = wr_ram_data_i;
            rd_d          = rd_i;
            funct3_d      = funct3_i;
            mem_read_d    = mem_read_i;
            mem_write_d   = mem_write_i;
            reg_write_d   = reg_write_i;
            state_d = ((mem_read_i || mem_write_i) &&
                       !is_misaligned(funct3_i[1:0], alu_result_i[2:0])) ? REQ : IDLE;
        end else if ((state_q == REQ) && dmem_gnt_i) begin
            // stalled with a grant can only be a load
            state_d = RESP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            alu_result_q  <= '0;
            wr_ram_data_q <= '0;
            rd_q          <= '0;
            funct3_q      <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            reg_write_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_result_q  <= alu_result_d;
            wr_ram_data_q <= wr_ram_data_d;
            rd_q          <= rd_d;
            funct3_q      <= funct3_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            reg_write_q   <= reg_write_d;
        end
    end

    // Request side: lane steering for stores
    always_comb begin
        dmem_req_o  = (state_q == REQ);
        dmem_we_o   = is_store;
        dmem_addr_o = {alu_result_q[XLEN-1:3], 3'b000};
        case (funct3_q[1:0])
            2'd0: begin
                dmem_be_o    = BE_W'(1) << off;
                dmem_wdata_o = {8{wr_ram_data_q[7:0]}};
            end
            2'd1: begin
                dmem_be_o    = BE_W'(3) << off;
                dmem_wdata_o = {4{wr_ram_data_q[15:0]}};
            end
            2'd2: begin
                dmem_be_o    = BE_W'(15) << off;
                dmem_wdata_o = {2{wr_ram_data_q[31:0]}};
            end
            default: begin
                dmem_be_o    = '1;
                dmem_wdata_o = wr_ram_data_q;
            end
        endcase
    end

    // Response side: lane select and sign/zero extension
    always_comb begin
        shifted = dmem_rdata_i >> {off, 3'b000};
        case (funct3_q[1:0])
            2'd0:    load_val = funct3_q[2] ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                            : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            2'd1:    load_val = funct3_q[2] ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                            : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            2'd2:    load_val = funct3_q[2] ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                            : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            default: load_val = dmem_rdata_i;
        endcase
    end

    always_comb begin
        mem_result_o = alu_result_q;
        if ((state_q == RESP) && dmem_rvalid_i) mem_result_o = load_val;
        rd_o        = rd_q;
        reg_write_o = reg_write_q & ~stall_o & ~misalign;
        misalign_o  = misalign;
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: table vectors, hand-written corner sequences and
// randomized ops against a byte-level reference model of mem_access_stage.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [63:0] alu_result_i, wr_ram_data_i;
    logic [4:0]  rd_i;
    logic [2:0]  funct3_i;
    logic        mem_read_i, mem_write_i, reg_write_i;
    logic        dmem_req_o, dmem_we_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o;
    logic [7:0]  dmem_be_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [63:0] dmem_rdata_i;
    logic [63:0] mem_result_o;
    logic [4:0]  rd_o;
    logic        reg_write_o, stall_o, misalign_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.XLEN(64), .BE_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .alu_result_i(alu_result_i), .wr_ram_data_i(wr_ram_data_i), .rd_i(rd_i),
        .funct3_i(funct3_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .reg_write_i(reg_write_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .mem_result_o(mem_result_o), .rd_o(rd_o), .reg_write_o(reg_write_o),
        .stall_o(stall_o), .misalign_o(misalign_o)
    );

    typedef struct {
        logic [63:0] alu, wd;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        mr, mw, rw;
        logic [63:0] rdata;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata, res;
        logic        mis;
        int          gd, rvd;
    } vec_t;

    vec_t tv[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h want 0x%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [63:0] alu, input logic [63:0] wd, input logic [4:0] rd,
                         input logic [2:0] f3, input logic mr, input logic mw, input logic rw);
        alu_result_i = alu; wr_ram_data_i = wd; rd_i = rd; funct3_i = f3;
        mem_read_i = mr; mem_write_i = mw; reg_write_i = rw;
    endtask

    task automatic nop();
        drive(64'd0, 64'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic vec_t mk(input logic [63:0] alu, input logic [63:0] wd, input logic [4:0] rd,
                                input logic [2:0] f3, input logic mr, input logic mw, input logic rw,
                                input logic [63:0] rdata, input logic [63:0] addr, input logic [7:0] be,
                                input logic [63:0] wdata, input logic [63:0] res, input logic mis,
                                input int gd, input int rvd);
        vec_t v;
        v.alu = alu; v.wd = wd; v.rd = rd; v.f3 = f3; v.mr = mr; v.mw = mw; v.rw = rw;
        v.rdata = rdata; v.addr = addr; v.be = be; v.wdata = wdata; v.res = res;
        v.mis = mis; v.gd = gd; v.rvd = rvd;
        return v;
    endfunction

    // Reference model: derived from byte-lane rules, not from the RTL structure.
    function automatic vec_t model(input logic [63:0] alu, input logic [63:0] wd, input logic [4:0] rd,
                                   input logic [2:0] f3, input logic mr, input logic mw, input logic rw,
                                   input logic [63:0] rdata);
        vec_t v;
        int unsigned n, o;
        logic [63:0] mask, val;
        n = 1 << f3[1:0];
        o = 32'(alu[2:0]);
        v = mk(alu, wd, rd, f3, mr, mw, rw, rdata, 64'd0, 8'd0, 64'd0, 64'd0, 1'b0, 0, 0);
        v.mis  = (mr || mw) && ((o % n) != 0);
        v.addr = alu & ~64'h7;
        for (int i = 0; i < 8; i++) begin
            v.be[i] = (i >= int'(o)) && (i < int'(o + n));
            v.wdata[i*8 +: 8] = wd[(i % int'(n))*8 +: 8];
        end
        mask = (n == 8) ? '1 : ((64'd1 << (8*n)) - 64'd1);
        val  = (rdata >> (8*o)) & mask;
        if (!f3[2] && n < 8 && val[8*n-1]) val = val | ~mask;
        v.res = (mr && !mw) ? val : alu;
        return v;
    endfunction

    // Starts and ends #1 after a posedge with the DUT idle and a nop driven.
    task automatic apply(input vec_t v, input string tag);
        drive(v.alu, v.wd, v.rd, v.f3, v.mr, v.mw, v.rw);
        tick();
        nop();
        chk({tag, " misalign"}, 64'(misalign_o), 64'(v.mis));
        chk({tag, " rd_o"}, 64'(rd_o), 64'(v.rd));
        if (v.mis || !(v.mr || v.mw)) begin
            chk({tag, " req"}, 64'(dmem_req_o), 64'd0);
            chk({tag, " stall"}, 64'(stall_o), 64'd0);
            chk({tag, " reg_write"}, 64'(reg_write_o), v.mis ? 64'd0 : 64'(v.rw));
            if (!v.mis) chk({tag, " result"}, mem_result_o, v.alu);
            tick();
        end else begin
            for (int k = 0; k <= v.gd; k++) begin
                dmem_rvalid_i = (k < v.gd) ? 1'($urandom % 2) : 1'b0;
                dmem_gnt_i = (k == v.gd);
                #1;
                chk({tag, " req"}, 64'(dmem_req_o), 64'd1);
                chk({tag, " we"}, 64'(dmem_we_o), 64'(v.mw));
                chk({tag, " addr"}, dmem_addr_o, v.addr);
                if (v.mw) begin
                    chk({tag, " be"}, 64'(dmem_be_o), 64'(v.be));
                    chk({tag, " wdata"}, dmem_wdata_o, v.wdata);
                end
                chk({tag, " stall"}, 64'(stall_o), (v.mw && k == v.gd) ? 64'd0 : 64'd1);
                chk({tag, " reg_write"}, 64'(reg_write_o), (v.mw && k == v.gd) ? 64'(v.rw) : 64'd0);
                tick();
            end
            dmem_gnt_i = 1'b0;
            dmem_rvalid_i = 1'b0;
            if (!v.mw) begin
                for (int k = 0; k < v.rvd; k++) begin
                    dmem_gnt_i = 1'($urandom % 2);
                    #1;
                    chk({tag, " resp req"}, 64'(dmem_req_o), 64'd0);
                    chk({tag, " resp stall"}, 64'(stall_o), 64'd1);
                    tick();
                end
                dmem_gnt_i = 1'b0;
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i = v.rdata;
                #1;
                chk({tag, " result"}, mem_result_o, v.res);
                chk({tag, " done stall"}, 64'(stall_o), 64'd0);
                chk({tag, " done reg_write"}, 64'(reg_write_o), 64'(v.rw));
                tick();
                dmem_rvalid_i = 1'b0;
                dmem_rdata_i = {$urandom, $urandom};
            end
        end
    endtask

    initial begin
        vec_t v;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        rst_ni = 1'b0;
        drive(64'hFFFF, 64'h55, 5'd7, 3'd3, 1'b1, 1'b0, 1'b1);
        tick(); tick();
        chk("rst req", 64'(dmem_req_o), 64'd0);
        chk("rst stall", 64'(stall_o), 64'd0);
        chk("rst reg_write", 64'(reg_write_o), 64'd0);
        chk("rst misalign", 64'(misalign_o), 64'd0);
        chk("rst result", mem_result_o, 64'd0);
        chk("rst rd", 64'(rd_o), 64'd0);
        nop();
        rst_ni = 1'b1;
        tick();

        //          alu                    wd                     rd  f3  mr mw rw rdata                  addr       be     wdata                  res                    mis gd rvd
        tv[0]  = mk(64'h1234,              64'd0,                 5,  0,  0, 0, 1, 64'd0,                 64'd0,     8'h00, 64'd0,                 64'h1234,              0,  0, 0);
        tv[1]  = mk(64'hFFFF_0000_0000_0001, 64'd0,               3,  0,  0, 0, 0, 64'd0,                 64'd0,     8'h00, 64'd0,                 64'hFFFF_0000_0000_0001, 0, 0, 0);
        tv[2]  = mk(64'h1006,              64'hABCD,              0,  1,  0, 1, 0, 64'd0,                 64'h1000,  8'hC0, 64'hABCD_ABCD_ABCD_ABCD, 64'd0,               0,  3, 0);
        tv[3]  = mk(64'h2003,              64'd0,                 7,  0,  1, 0, 1, 64'h0000_0000_8000_0000, 64'h2000, 8'h00, 64'd0,                 64'hFFFF_FFFF_FFFF_FF80, 0,  1, 2);
        tv[4]  = mk(64'h2003,              64'd0,                 7,  4,  1, 0, 1, 64'h0000_0000_8000_0000, 64'h2000, 8'h00, 64'd0,                 64'h80,                0,  1, 2);
        tv[5]  = mk(64'h2004,              64'd0,                 8,  2,  1, 0, 1, 64'h8765_4321_0000_0000, 64'h2000, 8'h00, 64'd0,                 64'hFFFF_FFFF_8765_4321, 0,  0, 0);
        tv[6]  = mk(64'h2004,              64'd0,                 8,  6,  1, 0, 1, 64'h8765_4321_0000_0000, 64'h2000, 8'h00, 64'd0,                 64'h0000_0000_8765_4321, 0,  0, 1);
        tv[7]  = mk(64'h2000,              64'd0,                 9,  3,  1, 0, 1, 64'h8765_4321_0000_0000, 64'h2000, 8'h00, 64'd0,                 64'h8765_4321_0000_0000, 0,  2, 0);
        tv[8]  = mk(64'h3002,              64'd0,                 4,  2,  1, 0, 1, 64'd0,                 64'h3000,  8'h00, 64'd0,                 64'd0,                 1,  0, 0);
        tv[9]  = mk(64'h15,                64'h1234_56EF,         0,  0,  0, 1, 0, 64'd0,                 64'h10,    8'h20, 64'hEFEF_EFEF_EFEF_EFEF, 64'd0,               0,  0, 0);
        tv[10] = mk(64'h18,                64'h1122_3344_5566_7788, 0, 3, 0, 1, 0, 64'd0,                 64'h18,    8'hFF, 64'h1122_3344_5566_7788, 64'd0,               0,  1, 0);
        tv[11] = mk(64'h24,                64'hDEAD_BEEF,         0,  2,  0, 1, 0, 64'd0,                 64'h20,    8'hF0, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0,               0,  2, 0);
        tv[12] = mk(64'h2006,              64'd0,                 10, 1,  1, 0, 1, 64'h8001_0000_0000_0000, 64'h2000, 8'h00, 64'd0,                 64'hFFFF_FFFF_FFFF_8001, 0,  0, 3);
        tv[13] = mk(64'h2006,              64'd0,                 10, 5,  1, 0, 1, 64'h8001_0000_0000_0000, 64'h2000, 8'h00, 64'd0,                 64'h8001,              0,  1, 1);
        tv[14] = mk(64'h4004,              64'd0,                 0,  3,  0, 1, 1, 64'd0,                 64'h4000,  8'h00, 64'd0,                 64'd0,                 1,  0, 0);
        tv[15] = mk(64'h5001,              64'h7A,                11, 0,  1, 1, 0, 64'd0,                 64'h5000,  8'h02, 64'h7A7A_7A7A_7A7A_7A7A, 64'd0,               0,  1, 0);

        for (int i = 0; i < 16; i++) apply(tv[i], $sformatf("tv%0d", i));

        // Back-to-back: store granted at once, load captured at the same edge.
        drive(64'h40, 64'h0102_0304_0506_0708, 5'd0, 3'd3, 1'b0, 1'b1, 1'b0);
        tick();
        drive(64'h48, 64'd0, 5'd9, 3'd3, 1'b1, 1'b0, 1'b1);
        chk("b2b st req", 64'(dmem_req_o), 64'd1);
        chk("b2b st addr", dmem_addr_o, 64'h40);
        dmem_gnt_i = 1'b1; #1;
        chk("b2b st stall", 64'(stall_o), 64'd0);
        tick();
        chk("b2b ld req", 64'(dmem_req_o), 64'd1);
        chk("b2b ld we", 64'(dmem_we_o), 64'd0);
        chk("b2b ld addr", dmem_addr_o, 64'h48);
        nop();
        tick();
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hCAFE_F00D_1234_5678; #1;
        chk("b2b ld result", mem_result_o, 64'hCAFE_F00D_1234_5678);
        chk("b2b ld reg_write", 64'(reg_write_o), 64'd1);
        chk("b2b ld rd", 64'(rd_o), 64'd9);
        tick();
        dmem_rvalid_i = 1'b0;

        // Stray handshakes while idle.
        tick();
        dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; #1;
        chk("stray req", 64'(dmem_req_o), 64'd0);
        chk("stray stall", 64'(stall_o), 64'd0);
        tick();
        chk("stray after req", 64'(dmem_req_o), 64'd0);
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;

        // Reset while waiting for load data; late rvalid must be ignored.
        drive(64'h60, 64'd0, 5'd12, 3'd3, 1'b1, 1'b0, 1'b1);
        tick();
        nop();
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0; #1;
        chk("rstmid in resp", 64'(stall_o), 64'd1);
        rst_ni = 1'b0;
        tick();
        chk("rstmid req", 64'(dmem_req_o), 64'd0);
        chk("rstmid stall", 64'(stall_o), 64'd0);
        rst_ni = 1'b1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD; #1;
        chk("late rv stall", 64'(stall_o), 64'd0);
        chk("late rv reg_write", 64'(reg_write_o), 64'd0);
        chk("late rv result", mem_result_o, 64'd0);
        tick();
        dmem_rvalid_i = 1'b0;
        chk("late rv req", 64'(dmem_req_o), 64'd0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 200; i++) begin
            int unsigned kind;
            logic [2:0] f3;
            logic mr, mw;
            kind = $urandom % 3;
            f3 = 3'($urandom % 7);
            mr = (kind == 1);
            mw = (kind == 2);
            if (mw) f3 = {1'b0, f3[1:0]};
            v = model({$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), f3, mr, mw,
                      1'($urandom % 2), {$urandom, $urandom});
            v.gd = int'($urandom % 4);
            v.rvd = int'($urandom % 4);
            apply(v, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
